// File: rtl/rggen_indirect_access_controller.sv
// Indirect register access sequencer: turns one index+read/write request into
// an index-register write followed by a data-register access on the register
// bus. The last successfully written index is cached so a repeat skips the
// index write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; latch it and pick INDEX or DATA
// INDEX    | writing the index value to INDEX_ADDRESS
// DATA     | read or write at DATA_ADDRESS using the latched request
// RESPONSE | holding the response until the requester takes it
module rggen_indirect_access_controller #(
   parameter int                       ADDRESS_WIDTH = 8,
   parameter int                       BUS_WIDTH     = 32,
   parameter int                       INDEX_WIDTH   = 8,
   parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = 'h00,
   parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = 'h04,
   parameter bit                       INDEX_CACHE   = 1'b1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [INDEX_WIDTH-1:0]     i_req_index,
   input  logic                       i_req_write,
   input  logic [BUS_WIDTH-1:0]       i_req_write_data,
   input  logic [BUS_WIDTH/8-1:0]     i_req_strobe,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [BUS_WIDTH-1:0]       o_rsp_read_data,
   output logic [1:0]                 o_rsp_status,
   input  logic                       i_cache_clear,
   output logic                       o_bus_valid,
   input  logic                       i_bus_ready,
   output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
   output logic                       o_bus_write,
   output logic [BUS_WIDTH-1:0]       o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
   input  logic [BUS_WIDTH-1:0]       i_bus_read_data,
   input  logic [1:0]                 i_bus_status
);

   localparam int STRB_W = BUS_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      INDEX    = 2'd1,
      DATA     = 2'd2,
      RESPONSE = 2'd3
   } state_t;

   state_t                   r_state, w_state_next;
   logic [INDEX_WIDTH-1:0]   r_req_index, w_req_index_next;
   logic                     r_req_write, w_req_write_next;
   logic [BUS_WIDTH-1:0]     r_req_wdata, w_req_wdata_next;
   logic [STRB_W-1:0]        r_req_strobe, w_req_strobe_next;
   logic                     r_cache_valid, w_cache_valid_next;
   logic [INDEX_WIDTH-1:0]   r_cache_index, w_cache_index_next;
   logic                     r_req_ready, w_req_ready_next;
   logic                     r_rsp_valid, w_rsp_valid_next;
   logic [BUS_WIDTH-1:0]     r_rsp_data, w_rsp_data_next;
   logic [1:0]               r_rsp_status, w_rsp_status_next;
   logic                     r_bus_valid, w_bus_valid_next;
   logic [ADDRESS_WIDTH-1:0] r_bus_address, w_bus_address_next;
   logic                     r_bus_write, w_bus_write_next;
   logic [BUS_WIDTH-1:0]     r_bus_wdata, w_bus_wdata_next;
   logic [STRB_W-1:0]        r_bus_strobe, w_bus_strobe_next;
   logic [BUS_WIDTH-1:0]     w_index_ext;
   logic                     w_hit;

   assign w_hit = INDEX_CACHE && r_cache_valid && (i_req_index == r_cache_index);

   // Next state, request latch, cache and response capture; bus and handshake
   // outputs are derived from the next state so they can be registered.
   always_comb begin
      w_state_next       = r_state;
      w_req_index_next   = r_req_index;
      w_req_write_next   = r_req_write;
      w_req_wdata_next   = r_req_wdata;
      w_req_strobe_next  = r_req_strobe;
      w_cache_valid_next = r_cache_valid;
      w_cache_index_next = r_cache_index;
      w_rsp_data_next    = r_rsp_data;
      w_rsp_status_next  = r_rsp_status;

      case (r_state)
         IDLE: begin
            if (i_req_valid) begin
               w_req_index_next  = i_req_index;
               w_req_write_next  = i_req_write;
               w_req_wdata_next  = i_req_write_data;
               w_req_strobe_next = i_req_strobe;
               w_state_next      = w_hit ? DATA : INDEX;
            end
         end
         INDEX: begin
            if (i_bus_ready) begin
               if (!i_bus_status[1]) begin
                  w_cache_index_next = r_req_index;
                  w_cache_valid_next = INDEX_CACHE;
                  w_state_next       = DATA;
               end else begin
                  w_cache_valid_next = 1'b0;
                  w_rsp_status_next  = i_bus_status;
                  w_rsp_data_next    = '0;
                  w_state_next       = RESPONSE;
               end
            end
         end
         DATA: begin
            if (i_bus_ready) begin
               w_rsp_status_next = i_bus_status;
               w_rsp_data_next   = r_req_write ? '0 : i_bus_read_data;
               w_state_next      = RESPONSE;
            end
         end
         RESPONSE: begin
            if (i_rsp_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase

      // A clear that lands together with a successful index write still wins.
      if (i_cache_clear) w_cache_valid_next = 1'b0;

      w_index_ext                  = '0;
      w_index_ext[INDEX_WIDTH-1:0] = w_req_index_next;

      w_req_ready_next   = (w_state_next == IDLE);
      w_rsp_valid_next   = (w_state_next == RESPONSE);
      w_bus_valid_next   = 1'b0;
      w_bus_address_next = '0;
      w_bus_write_next   = 1'b0;
      w_bus_wdata_next   = '0;
      w_bus_strobe_next  = '0;
      if (w_state_next == INDEX) begin
         w_bus_valid_next   = 1'b1;
         w_bus_address_next = INDEX_ADDRESS;
         w_bus_write_next   = 1'b1;
         w_bus_wdata_next   = w_index_ext;
         w_bus_strobe_next  = '1;
      end else if (w_state_next == DATA) begin
         w_bus_valid_next   = 1'b1;
         w_bus_address_next = DATA_ADDRESS;
         w_bus_write_next   = w_req_write_next;
         w_bus_wdata_next   = w_req_wdata_next;
         w_bus_strobe_next  = w_req_strobe_next;
      end
   end

   // State, request, cache and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_req_index   <= '0;
         r_req_write   <= 1'b0;
         r_req_wdata   <= '0;
         r_req_strobe  <= '0;
         r_cache_valid <= 1'b0;
         r_cache_index <= '0;
         r_req_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_status  <= '0;
         r_bus_valid   <= 1'b0;
         r_bus_address <= '0;
         r_bus_write   <= 1'b0;
         r_bus_wdata   <= '0;
         r_bus_strobe  <= '0;
      end else begin
         r_state       <= w_state_next;
         r_req_index   <= w_req_index_next;
         r_req_write   <= w_req_write_next;
         r_req_wdata   <= w_req_wdata_next;
         r_req_strobe  <= w_req_strobe_next;
         r_cache_valid <= w_cache_valid_next;
         r_cache_index <= w_cache_index_next;
         r_req_ready   <= w_req_ready_next;
         r_rsp_valid   <= w_rsp_valid_next;
         r_rsp_data    <= w_rsp_data_next;
         r_rsp_status  <= w_rsp_status_next;
         r_bus_valid   <= w_bus_valid_next;
         r_bus_address <= w_bus_address_next;
         r_bus_write   <= w_bus_write_next;
         r_bus_wdata   <= w_bus_wdata_next;
         r_bus_strobe  <= w_bus_strobe_next;
      end
   end

   assign o_req_ready      = r_req_ready;
   assign o_rsp_valid      = r_rsp_valid;
   assign o_rsp_read_data  = r_rsp_data;
   assign o_rsp_status     = r_rsp_status;
   assign o_bus_valid      = r_bus_valid;
   assign o_bus_address    = r_bus_address;
   assign o_bus_write      = r_bus_write;
   assign o_bus_write_data = r_bus_wdata;
   assign o_bus_strobe     = r_bus_strobe;

endmodule

// File: doc/rggen_indirect_access_controller.md
Name: rggen_indirect_access_controller

Overview:
Bus-master sequencer that converts single indirect accesses (index + read/write) into the register-bus transactions an indirect register needs. First writes the index value to the index register at INDEX_ADDRESS, then performs the read or write at DATA_ADDRESS. The last index written is cached, so the index write is skipped on a repeat hit. Sits between a firmware/test-side request port and the register bus that feeds the register block.

Parameters:
ADDRESS_WIDTH, 8, register-bus address width
BUS_WIDTH, 32, register-bus data width
INDEX_WIDTH, 8, indirect index width; must be <= BUS_WIDTH
INDEX_ADDRESS, 'h00, byte address of the index register
DATA_ADDRESS, 'h04, byte address of the indirect data register
INDEX_CACHE, 1, 1 = skip the index write when the cached index matches; 0 = always write the index

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request ready
i_req_index  in  INDEX_WIDTH  indirect index
i_req_write  in  1  1 = write, 0 = read
i_req_write_data  in  BUS_WIDTH  write data
i_req_strobe  in  BUS_WIDTH/8  byte strobe for the data access
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response ready
o_rsp_read_data  out  BUS_WIDTH  read data; 0 for writes and failed index phase
o_rsp_status  out  2  00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR
i_cache_clear  in  1  invalidate the cached index
o_bus_valid  out  1  bus request valid
i_bus_ready  in  1  bus access complete
o_bus_address  out  ADDRESS_WIDTH  bus address
o_bus_write  out  1  bus write
o_bus_write_data  out  BUS_WIDTH  bus write data
o_bus_strobe  out  BUS_WIDTH/8  bus byte strobe
i_bus_read_data  in  BUS_WIDTH  bus read data
i_bus_status  in  2  bus status, same encoding as o_rsp_status

Behaviour:
- Reset (i_rst high at an i_clk edge) values:
  - state IDLE, cache invalid
  - o_req_ready=1; o_bus_valid=0; o_rsp_valid=0
  - all data, address, strobe and status outputs 0
- Reset mid-operation aborts immediately: o_bus_valid drops the next cycle and no response is produced.
- All outputs are registered. One request is outstanding at a time.
- State machine: IDLE, INDEX, DATA, RESPONSE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch index, write, write data and strobe.
  - Go to DATA if INDEX_CACHE=1, the cache is valid and the index equals the cached index; otherwise go to INDEX.
- INDEX:
  - o_bus_valid=1, address INDEX_ADDRESS, write=1, data = index zero-extended, strobe all ones.
  - Bus outputs stay stable until i_bus_ready.
  - On i_bus_ready with i_bus_status[1]=0: cached index <= index, cache valid, go to DATA.
  - On i_bus_ready with i_bus_status[1]=1: cache invalid, capture status, read data 0, go to RESPONSE.
- DATA:
  - o_bus_valid=1, address DATA_ADDRESS, write/data/strobe from the latched request; stable until i_bus_ready.
  - On i_bus_ready: capture status. For a read, capture i_bus_read_data; for a write, read data is 0. Go to RESPONSE.
  - A data-phase error does not invalidate the cache.
- RESPONSE:
  - o_rsp_valid=1, held with data and status stable until i_rsp_ready; then go to IDLE.
  - o_req_ready stays 0 until back in IDLE; no bypass of the response stage.
- Latency (i_bus_ready and i_rsp_ready tied high, accept in cycle 0):
  - cache hit: bus valid in cycle 1, response valid in cycle 2, next accept in cycle 3
  - miss: one extra cycle
- o_bus_valid deasserts in the cycle after i_bus_ready; no back-to-back bus cycles without a state change.
- i_cache_clear invalidates the cache at the next edge in any state. If it coincides with a successful index phase, clear wins: the cache ends invalid, and the current access still proceeds to DATA.
- INDEX_CACHE=0: cache-valid flag is never set; every request goes through INDEX.
- i_req_* inputs are ignored outside IDLE.

Test Plan:
- Reset, then read index 5; bus returns 'hDEADBEEF OKAY -> bus writes 5 to 'h00, then reads 'h04; response data 'hDEADBEEF, status 00; 4 cycles accept-to-accept with ready tied high.
- Second request, write index 5 data 'h12345678 strobe 'hF -> no index write; single bus write to 'h04; response data 0, status 00, issued 2 cycles after accept.
- Request index 6 with i_bus_ready delayed 3 cycles per phase -> bus address/data stay stable while waiting; index write then data access; cache now holds 6.
- Index phase returns status 10 -> no data access; response status 10, data 0; next request with the same index rewrites the index.
- Pulse i_cache_clear in the same cycle as a successful index write, then repeat the same index -> index write occurs again.
- Hold i_rsp_ready low 5 cycles, then assert i_rst mid-DATA -> response held stable while waiting; after reset: o_bus_valid=0, o_rsp_valid=0, o_req_ready=1, cache invalid.
